// File: rtl/mem_axi_pkg.sv
// Shared types and helpers for the mem_axi_master AXI4 front-end.
package mem_axi_pkg;

    typedef enum logic [2:0] {IDLE, WR, B, RD, RSP} state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // True when a burst starting at word index word_idx with len+1 beats runs past a 4KB page.
    function automatic logic crosses_4k(input logic [9:0] word_idx, input logic [7:0] len);
        logic [10:0] last_word;
        last_word = {1'b0, word_idx} + {3'b000, len};
        return last_word > 11'd1023;
    endfunction

endpackage

// File: rtl/mem_axi_skid.sv
// Two-entry FIFO decoupling the AXI R channel from the requester's rdata_ready_i.
// Only compiled when MEM_AXI_RSKID_EN is defined.
`ifdef MEM_AXI_RSKID_EN
module mem_axi_skid #(
    parameter int W = 33
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    output logic         full_o,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push_ok, pop_ok;

    assign full_o  = (cnt_q == 2'd2);
    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push_ok;
        rd_ptr_d = rd_ptr_q ^ pop_ok;
        cnt_d    = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_ok) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/mem_axi_master.sv
// Native burst request port to AXI4 INCR master, 32-bit data, one transaction outstanding.
// Define MEM_AXI_RSKID_EN to insert a 2-entry skid FIFO on the read data path.
module mem_axi_master #(
    parameter logic [3:0] AXI_ID  = 4'h0,
    parameter logic [7:0] MAX_LEN = 8'd15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [7:0]  req_len_i,
    input  logic        wdata_valid_i,
    output logic        wdata_ready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic        rdata_valid_o,
    input  logic        rdata_ready_i,
    output logic [31:0] rdata_o,
    output logic        rdata_last_o,
    output logic        done_o,
    output logic        err_o,
    output logic        m_awvalid_o,
    input  logic        m_awready_i,
    output logic [31:0] m_awaddr_o,
    output logic [3:0]  m_awid_o,
    output logic [7:0]  m_awlen_o,
    output logic [1:0]  m_awburst_o,
    output logic        m_wvalid_o,
    input  logic        m_wready_i,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wstrb_o,
    output logic        m_wlast_o,
    input  logic        m_bvalid_i,
    output logic        m_bready_o,
    input  logic [1:0]  m_bresp_i,
    input  logic [3:0]  m_bid_i,
    output logic        m_arvalid_o,
    input  logic        m_arready_i,
    output logic [31:0] m_araddr_o,
    output logic [3:0]  m_arid_o,
    output logic [7:0]  m_arlen_o,
    output logic [1:0]  m_arburst_o,
    input  logic        m_rvalid_i,
    output logic        m_rready_o,
    input  logic [31:0] m_rdata_i,
    input  logic [1:0]  m_rresp_i,
    input  logic [3:0]  m_rid_i,
    input  logic        m_rlast_i
);

    import mem_axi_pkg::*;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        ar_done_q, ar_done_d;

    logic w_active, w_last, aw_hs, w_hs, ar_hs, r_hs, r_phase, r_is_last, r_end;

    assign req_ready_o = (state_q == IDLE);
    assign done_o      = (state_q == RSP);
    assign err_o       = done_o && err_q;

    assign m_awvalid_o = (state_q == WR) && !aw_done_q;
    assign m_awaddr_o  = addr_q;
    assign m_awlen_o   = len_q;
    assign m_awid_o    = AXI_ID;
    assign m_awburst_o = AXI_BURST_INCR;
    assign aw_hs       = m_awvalid_o && m_awready_i;

    // W beats stream straight through; the gate stops beats after wlast.
    assign w_active      = (state_q == WR) && !w_done_q;
    assign w_last        = (cnt_q == len_q);
    assign m_wvalid_o    = w_active && wdata_valid_i;
    assign wdata_ready_o = w_active && m_wready_i;
    assign m_wdata_o     = wdata_i;
    assign m_wstrb_o     = wstrb_i;
    assign m_wlast_o     = w_active && w_last;
    assign w_hs          = m_wvalid_o && m_wready_i;

    assign m_bready_o  = (state_q == B);

    assign m_arvalid_o = (state_q == RD) && !ar_done_q;
    assign m_araddr_o  = addr_q;
    assign m_arlen_o   = len_q;
    assign m_arid_o    = AXI_ID;
    assign m_arburst_o = AXI_BURST_INCR;
    assign ar_hs       = m_arvalid_o && m_arready_i;

    assign r_is_last = (cnt_q == len_q);
    assign r_hs      = m_rvalid_i && m_rready_o;
    // A slave-signalled rlast also ends the burst so an early rlast cannot stall us.
    assign r_end     = r_hs && (r_is_last || m_rlast_i);

`ifdef MEM_AXI_RSKID_EN
    logic        r_done_q, r_done_d;
    logic        fifo_full, fifo_valid;
    logic [32:0] fifo_dout;

    mem_axi_skid #(.W(33)) u_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (r_hs),
        .data_i  ({m_rdata_i, r_is_last}),
        .full_o  (fifo_full),
        .pop_i   (rdata_ready_i),
        .valid_o (fifo_valid),
        .data_o  (fifo_dout)
    );

    assign r_phase       = (state_q == RD) && ar_done_q && !r_done_q;
    assign m_rready_o    = r_phase && !fifo_full;
    assign rdata_valid_o = fifo_valid;
    assign rdata_o       = fifo_dout[32:1];
    assign rdata_last_o  = fifo_valid && fifo_dout[0];
`else
    assign r_phase       = (state_q == RD) && ar_done_q;
    assign m_rready_o    = r_phase && rdata_ready_i;
    assign rdata_valid_o = r_phase && m_rvalid_i;
    assign rdata_o       = r_phase ? m_rdata_i : 32'h0;
    assign rdata_last_o  = rdata_valid_o && r_is_last;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        ar_done_d = ar_done_q;
`ifdef MEM_AXI_RSKID_EN
        r_done_d  = r_done_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d    = req_addr_i & 32'hFFFF_FFFC;
                    len_d     = req_len_i;
                    cnt_d     = 8'd0;
                    err_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    ar_done_d = 1'b0;
`ifdef MEM_AXI_RSKID_EN
                    r_done_d  = 1'b0;
`endif
                    if ((req_len_i > MAX_LEN) || crosses_4k(req_addr_i[11:2], req_len_i)) begin
                        err_d   = 1'b1;
                        state_d = RSP;
                    end else begin
                        state_d = req_we_i ? WR : RD;
                    end
                end
            end
            WR: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs) begin
                    if (w_last) w_done_d = 1'b1;
                    else        cnt_d    = cnt_q + 8'd1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && w_last)))
                    state_d = B;
            end
            B: begin
                if (m_bvalid_i) begin
                    err_d   = (m_bresp_i != AXI_RESP_OKAY) || (m_bid_i != AXI_ID);
                    state_d = RSP;
                end
            end
            RD: begin
                if (ar_hs) ar_done_d = 1'b1;
                if (r_hs) begin
                    if ((m_rresp_i != AXI_RESP_OKAY) || (m_rid_i != AXI_ID) ||
                        (m_rlast_i != r_is_last))
                        err_d = 1'b1;
                    if (!r_end) cnt_d = cnt_q + 8'd1;
                end
`ifdef MEM_AXI_RSKID_EN
                if (r_end) r_done_d = 1'b1;
                if (r_done_q && !fifo_valid) state_d = RSP;
`else
                if (r_end) state_d = RSP;
`endif
            end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= 32'h0;
            len_q     <= 8'h0;
            cnt_q     <= 8'h0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
`ifdef MEM_AXI_RSKID_EN
            r_done_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ar_done_q <= ar_done_d;
`ifdef MEM_AXI_RSKID_EN
            r_done_q  <= r_done_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_axi_master.sv
// Scoreboard bench for mem_axi_master: directed requests, reactive AXI slave, negedge monitor.
module tb_mem_axi_master;

    localparam logic [3:0] TB_ID = 4'h3;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [31:0] req_addr_i;
    logic [7:0]  req_len_i;
    logic        wdata_valid_i, wdata_ready_o;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        rdata_valid_o, rdata_ready_i, rdata_last_o;
    logic [31:0] rdata_o;
    logic        done_o, err_o;
    logic        m_awvalid_o, m_awready_i;
    logic [31:0] m_awaddr_o;
    logic [3:0]  m_awid_o;
    logic [7:0]  m_awlen_o;
    logic [1:0]  m_awburst_o;
    logic        m_wvalid_o, m_wready_i, m_wlast_o;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_wstrb_o;
    logic        m_bvalid_i, m_bready_o;
    logic [1:0]  m_bresp_i;
    logic [3:0]  m_bid_i;
    logic        m_arvalid_o, m_arready_i;
    logic [31:0] m_araddr_o;
    logic [3:0]  m_arid_o;
    logic [7:0]  m_arlen_o;
    logic [1:0]  m_arburst_o;
    logic        m_rvalid_i, m_rready_o, m_rlast_i;
    logic [31:0] m_rdata_i;
    logic [1:0]  m_rresp_i;
    logic [3:0]  m_rid_i;

    always #5 clk_i = ~clk_i;

    mem_axi_master #(.AXI_ID(TB_ID), .MAX_LEN(8'd15)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i),
        .rdata_o(rdata_o), .rdata_last_o(rdata_last_o),
        .done_o(done_o), .err_o(err_o),
        .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i), .m_awaddr_o(m_awaddr_o),
        .m_awid_o(m_awid_o), .m_awlen_o(m_awlen_o), .m_awburst_o(m_awburst_o),
        .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i), .m_wdata_o(m_wdata_o),
        .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o),
        .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o), .m_bresp_i(m_bresp_i), .m_bid_i(m_bid_i),
        .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_araddr_o(m_araddr_o),
        .m_arid_o(m_arid_o), .m_arlen_o(m_arlen_o), .m_arburst_o(m_arburst_o),
        .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rdata_i(m_rdata_i),
        .m_rresp_i(m_rresp_i), .m_rid_i(m_rid_i), .m_rlast_i(m_rlast_i)
    );

    int checks = 0;
    int errors = 0;
    int r_seen = 0;

    logic [39:0] exp_aw[$];
    logic [36:0] exp_w[$];
    logic [39:0] exp_ar[$];
    logic [32:0] exp_r[$];
    logic        exp_done[$];

    bit          w_bp = 1'b0;
    bit          r_bp = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [31:0] rd_base = 32'h0;
    int          early_beat = 1000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got handshake expected none", name);
    endtask

    function automatic logic [31:0] beat_data(input logic [31:0] base, input int i);
        return base + 32'(i) * 32'h0101_0101;
    endfunction

    function automatic logic [3:0] beat_strb(input logic [3:0] s0, input int i);
        return (i % 2 == 1) ? ~s0 : s0;
    endfunction

    // Reactive AXI slave: ready follows valid by one cycle, B after AW and last W, R beats rd_base+i.
    initial begin : slave
        bit aw_hs, wl_hs, b_hs, ar_hs, r_hs, aw_got, wl_got, r_act;
        logic [7:0] arlen_s, r_len;
        int r_cnt;
        aw_got = 0; wl_got = 0; r_act = 0; r_cnt = 0; r_len = 0;
        m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0; m_bresp_i = 0; m_bid_i = 0;
        m_arready_i = 0; m_rvalid_i = 0; m_rdata_i = 0; m_rresp_i = 0; m_rid_i = 0;
        m_rlast_i = 0; rdata_ready_i = 0;
        forever begin
            @(negedge clk_i);
            aw_hs   = m_awvalid_o && m_awready_i;
            wl_hs   = m_wvalid_o && m_wready_i && m_wlast_o;
            b_hs    = m_bvalid_i && m_bready_o;
            ar_hs   = m_arvalid_o && m_arready_i;
            r_hs    = m_rvalid_i && m_rready_o;
            arlen_s = m_arlen_o;
            @(posedge clk_i);
            #1;
            if (!rst_ni) begin
                aw_got = 0; wl_got = 0; r_act = 0; r_cnt = 0;
                m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0; m_arready_i = 0;
                m_rvalid_i = 0; m_rlast_i = 0; rdata_ready_i = 0;
                continue;
            end
            m_awready_i = m_awvalid_o;
            m_arready_i = m_arvalid_o;
            m_wready_i  = w_bp ? !m_wready_i : 1'b1;
            rdata_ready_i = r_bp ? !rdata_ready_i : 1'b1;
            if (aw_hs) aw_got = 1;
            if (wl_hs) wl_got = 1;
            if (b_hs) m_bvalid_i = 0;
            else if (aw_got && wl_got) begin
                m_bvalid_i = 1; m_bresp_i = bresp_cfg; m_bid_i = TB_ID;
                aw_got = 0; wl_got = 0;
            end
            if (r_hs) begin
                if (m_rlast_i) r_act = 0;
                else r_cnt++;
            end
            if (ar_hs) begin r_act = 1; r_cnt = 0; r_len = arlen_s; end
            m_rvalid_i = r_act;
            m_rdata_i  = rd_base + 32'(r_cnt);
            m_rlast_i  = r_act && ((r_cnt == int'(r_len)) || (r_cnt == early_beat));
            m_rresp_i  = 2'b00;
            m_rid_i    = TB_ID;
        end
    end

    initial begin : monitor
        logic [39:0] e40;
        logic [36:0] e37;
        logic [32:0] e33;
        logic        e1;
        bit aw_stall, w_stall, rd_stall;
        logic [39:0] aw_prev;
        logic [36:0] w_prev;
        logic [32:0] rd_prev;
        aw_stall = 0; w_stall = 0; rd_stall = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                aw_stall = 0; w_stall = 0; rd_stall = 0;
                continue;
            end
            if (aw_stall) chk("aw_hold", 64'({m_awvalid_o, m_awaddr_o, m_awlen_o}), 64'({1'b1, aw_prev}));
            if (w_stall)  chk("w_hold", 64'({m_wvalid_o, m_wdata_o, m_wstrb_o, m_wlast_o}), 64'({1'b1, w_prev}));
            if (rd_stall) chk("rdata_hold", 64'({rdata_valid_o, rdata_o, rdata_last_o}), 64'({1'b1, rd_prev}));
            if (m_awvalid_o && m_awready_i) begin
                if (exp_aw.size() == 0) unexpected("aw_unexpected");
                else begin
                    e40 = exp_aw.pop_front();
                    chk("aw_addr_len", 64'({m_awaddr_o, m_awlen_o}), 64'(e40));
                    chk("aw_id_burst", 64'({m_awid_o, m_awburst_o}), 64'({TB_ID, 2'b01}));
                end
            end
            if (m_wvalid_o && m_wready_i) begin
                if (exp_w.size() == 0) unexpected("w_unexpected");
                else begin
                    e37 = exp_w.pop_front();
                    chk("w_beat", 64'({m_wdata_o, m_wstrb_o, m_wlast_o}), 64'(e37));
                end
            end
            if (m_arvalid_o && m_arready_i) begin
                if (exp_ar.size() == 0) unexpected("ar_unexpected");
                else begin
                    e40 = exp_ar.pop_front();
                    chk("ar_addr_len", 64'({m_araddr_o, m_arlen_o}), 64'(e40));
                    chk("ar_id_burst", 64'({m_arid_o, m_arburst_o}), 64'({TB_ID, 2'b01}));
                end
            end
            if (rdata_valid_o && rdata_ready_i) begin
                r_seen++;
                if (exp_r.size() == 0) unexpected("rdata_unexpected");
                else begin
                    e33 = exp_r.pop_front();
                    chk("rdata_beat", 64'({rdata_o, rdata_last_o}), 64'(e33));
                end
            end
            if (done_o) begin
                if (exp_done.size() == 0) unexpected("done_unexpected");
                else begin
                    e1 = exp_done.pop_front();
                    chk("done_err", 64'(err_o), 64'(e1));
                end
            end
            aw_stall = m_awvalid_o && !m_awready_i;
            aw_prev  = {m_awaddr_o, m_awlen_o};
            w_stall  = m_wvalid_o && !m_wready_i;
            w_prev   = {m_wdata_o, m_wstrb_o, m_wlast_o};
            rd_stall = rdata_valid_o && !rdata_ready_i;
            rd_prev  = {rdata_o, rdata_last_o};
        end
    end

    task automatic issue(input bit we, input logic [31:0] addr, input logic [7:0] len);
        int n;
        req_valid_i = 1; req_we_i = we; req_addr_i = addr; req_len_i = len;
        n = 0;
        do begin @(negedge clk_i); n++; end while (!req_ready_o && n < 100);
        chk("req_accept", 64'(req_ready_o), 64'(1));
        @(posedge clk_i);
        #1;
        req_valid_i = 0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin @(negedge clk_i); n++; end while (!done_o && n < 200);
        chk({name, "_done"}, 64'(done_o), 64'(1));
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [7:0] len,
                             input logic [31:0] dbase, input logic [3:0] s0, input bit exp_err);
        int n;
        exp_aw.push_back({addr & 32'hFFFF_FFFC, len});
        for (int i = 0; i <= int'(len); i++)
            exp_w.push_back({beat_data(dbase, i), beat_strb(s0, i), (i == int'(len))});
        exp_done.push_back(exp_err);
        issue(1'b1, addr, len);
        chk("aw_latency", 64'(m_awvalid_o), 64'(1));
        for (int i = 0; i <= int'(len); i++) begin
            wdata_valid_i = 1; wdata_i = beat_data(dbase, i); wstrb_i = beat_strb(s0, i);
            n = 0;
            do begin @(negedge clk_i); n++; end while (!wdata_ready_o && n < 50);
            chk("wbeat_accept", 64'(wdata_ready_o), 64'(1));
            @(posedge clk_i);
            #1;
        end
        wdata_valid_i = 0;
        wait_done("wr");
    endtask

    task automatic read_txn(input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] base, input int early, input bit exp_err);
        int nb;
        rd_base = base; early_beat = early;
        nb = (early < int'(len)) ? early + 1 : int'(len) + 1;
        exp_ar.push_back({addr & 32'hFFFF_FFFC, len});
        for (int i = 0; i < nb; i++) exp_r.push_back({base + 32'(i), (i == int'(len))});
        exp_done.push_back(exp_err);
        issue(1'b0, addr, len);
        chk("ar_latency", 64'(m_arvalid_o), 64'(1));
        wait_done("rd");
        early_beat = 1000;
    endtask

    task automatic reject_txn(input bit we, input logic [31:0] addr, input logic [7:0] len);
        exp_done.push_back(1'b1);
        issue(we, addr, len);
        @(negedge clk_i);
        chk("rej_done", 64'(done_o), 64'(1));
        chk("rej_err", 64'(err_o), 64'(1));
        chk("rej_no_axi", 64'({m_awvalid_o, m_arvalid_o, m_wvalid_o}), 64'(0));
        @(posedge clk_i);
        #1;
        chk("rej_back_idle", 64'({req_ready_o, done_o}), 64'(2'b10));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        req_valid_i = 0; req_we_i = 0; req_addr_i = 0; req_len_i = 0;
        wdata_valid_i = 0; wdata_i = 0; wstrb_i = 0;
        rst_ni = 0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valids", 64'({m_awvalid_o, m_arvalid_o, m_wvalid_o, rdata_valid_o}), 64'(0));
        chk("rst_readys", 64'({wdata_ready_o, m_bready_o, m_rready_o}), 64'(0));
        chk("rst_done_err_last", 64'({done_o, err_o, rdata_last_o, m_wlast_o}), 64'(0));
        chk("rst_addr_len", 64'({m_awaddr_o, m_awlen_o}), 64'(0));
        chk("rst_burst", 64'({m_awburst_o, m_arburst_o}), 64'(4'b0101));
        rst_ni = 1;
        @(posedge clk_i);
        #1;
        chk("idle_req_ready", 64'(req_ready_o), 64'(1));

        write_txn(32'h100, 8'd0, 32'hDEAD_BEEF, 4'hF, 1'b0);
        read_txn(32'h200, 8'd3, 32'h0, 1000, 1'b0);

        w_bp = 1;
        write_txn(32'h303, 8'd3, 32'hA5A5_0000, 4'h3, 1'b0);
        w_bp = 0;
        r_bp = 1;
        read_txn(32'h400, 8'd2, 32'h1000, 1000, 1'b0);
        r_bp = 0;

        write_txn(32'hFF0, 8'd3, 32'h1234_5678, 4'hC, 1'b0);
        reject_txn(1'b1, 32'hFF8, 8'd3);
        reject_txn(1'b0, 32'h000, 8'd16);

        bresp_cfg = 2'b10;
        write_txn(32'h500, 8'd1, 32'hCAFE_0000, 4'h9, 1'b1);
        bresp_cfg = 2'b00;
        read_txn(32'h600, 8'd3, 32'h20, 1, 1'b1);

        wdata_valid_i = 1; wdata_i = 32'hBAD0_BAD0; wstrb_i = 4'hF;
        @(negedge clk_i);
        chk("extra_beat_blocked", 64'({wdata_ready_o, m_wvalid_o}), 64'(0));
        @(posedge clk_i);
        #1;
        wdata_valid_i = 0;

        rd_base = 32'h0;
        exp_ar.push_back({32'h800, 8'd3});
        for (int i = 0; i < 4; i++) exp_r.push_back({32'(i), (i == 3)});
        exp_done.push_back(1'b0);
        r_seen = 0;
        issue(1'b0, 32'h800, 8'd3);
        n = 0;
        do begin @(posedge clk_i); #1; n++; end while (r_seen < 2 && n < 100);
        chk("mid_beats_seen", 64'(r_seen), 64'(2));
        rst_ni = 0;
        #1;
        chk("mid_rst_valids", 64'({m_awvalid_o, m_arvalid_o, m_wvalid_o, rdata_valid_o, done_o}), 64'(0));
        chk("mid_rst_readys", 64'({m_rready_o, m_bready_o, wdata_ready_o, req_ready_o}), 64'(4'b0001));
        exp_r.delete();
        exp_done.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1;
        @(posedge clk_i);
        #1;
        write_txn(32'h700, 8'd1, 32'h0BAD_F00D, 4'h5, 1'b0);
        read_txn(32'h900, 8'd1, 32'h55, 1000, 1'b0);

        repeat (3) @(posedge clk_i);
        #1;
        chk("q_aw_empty", 64'(exp_aw.size()), 64'(0));
        chk("q_w_empty", 64'(exp_w.size()), 64'(0));
        chk("q_ar_empty", 64'(exp_ar.size()), 64'(0));
        chk("q_r_empty", 64'(exp_r.size()), 64'(0));
        chk("q_done_empty", 64'(exp_done.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
